// File: rtl/wall_query_arb_pkg.sv
// Shared definitions for the wall-query arbiter: map geometry, FSM encoding,
// requester slot assignments and the round-robin pointer helper.
package wall_query_arb_pkg;

    localparam int MAP_W  = 200;
    localparam int MAP_H  = 144;
    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int TANK1 = 0;
    localparam int TANK2 = 1;
    localparam int BUL1  = 2;
    localparam int BUL2  = 3;

    // Index following idx in an n-entry ring.
    function automatic int rr_next(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wall_query_arb_if.sv
// Requester/map-side bundle of the wall-query arbiter; slave is the arbiter,
// master is whatever drives the requests and the map result.
interface wall_query_arb_if #(
    parameter int NREQ = 4,
    parameter int CW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] req_x;
    logic [NREQ*CW-1:0] req_y;
    logic [NREQ-1:0]    ack;
    logic               hit;
    logic               busy;
    logic [CW-1:0]      map_x;
    logic [CW-1:0]      map_y;
    logic               map_hit;

    modport master (
        output req, req_x, req_y, map_hit,
        input  ack, hit, busy, map_x, map_y
    );

    modport slave (
        input  req, req_x, req_y, map_hit,
        output ack, hit, busy, map_x, map_y
    );
endinterface

// File: rtl/wall_query_arb_rr_pick.sv
// Combinational round-robin picker: first pending requester at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant,
    output logic            any
);

    logic [IW:0]     idx_sum [NREQ];
    logic [IW-1:0]   idx     [NREQ];
    logic [NREQ-1:0] rot;

    // rot[gi] is the requester gi places after ptr, so rot[0] has top priority.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign idx_sum[gi] = {1'b0, ptr} + (IW+1)'(gi);
        assign idx[gi]     = (idx_sum[gi] >= (IW+1)'(NREQ))
                           ? IW'(idx_sum[gi] - (IW+1)'(NREQ))
                           : idx_sum[gi][IW-1:0];
        assign rot[gi]     = req[idx[gi]];
    end

    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant = idx[i];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wall_query_arb.sv
// Round-robin arbiter sharing the map's single registered wall-lookup port
// between NREQ requesters; one-cycle ack carries the 1-bit wall result.
module wall_query_arb
    import wall_query_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CW      = CW_DEF,
    parameter int MAP_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    wall_query_arb_if.slave bus
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = (MAP_LAT > 0) ? $clog2(MAP_LAT + 1) : 1;

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   gid_reg;
    logic [CNTW-1:0] cnt_reg;
    logic [NREQ-1:0] ack_reg;
    logic            hit_reg;
    logic            busy_reg;
    logic [CW-1:0]   map_x_reg;
    logic [CW-1:0]   map_y_reg;

    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [CW-1:0]   coord_x [NREQ];
    logic [CW-1:0]   coord_y [NREQ];
    logic [CW-1:0]   sel_x_next;
    logic [CW-1:0]   sel_y_next;
    logic [IW-1:0]   ptr_next;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign coord_x[gi] = bus.req_x[gi*CW +: CW];
        assign coord_y[gi] = bus.req_y[gi*CW +: CW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .grant (pick_idx),
        .any   (pick_any)
    );

    assign sel_x_next = coord_x[pick_idx];
    assign sel_y_next = coord_y[pick_idx];
    assign ptr_next   = IW'(rr_next(int'(pick_idx), NREQ));

    // Coordinates are latched at grant, so requester changes during WAIT are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            gid_reg   <= '0;
            cnt_reg   <= '0;
            ack_reg   <= '0;
            hit_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            map_x_reg <= '0;
            map_y_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        map_x_reg <= sel_x_next;
                        map_y_reg <= sel_y_next;
                        gid_reg   <= pick_idx;
                        cnt_reg   <= CNTW'(MAP_LAT);
                        ptr_reg   <= ptr_next;
                        state_reg <= ST_WAIT;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        hit_reg   <= bus.map_hit;
                        ack_reg   <= NREQ'(1) << gid_reg;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ack_reg   <= '0;
                    hit_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    ack_reg   <= '0;
                    hit_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.hit   = hit_reg;
    assign bus.busy  = busy_reg;
    assign bus.map_x = map_x_reg;
    assign bus.map_y = map_y_reg;

endmodule

// File: tb/tb_wall_query_arb.sv
// Scoreboard bench for wall_query_arb: directed queries push expected acks,
// a monitor pops and compares each ack pulse; a small registered map model answers lookups.
module tb_wall_query_arb;
    import wall_query_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic            hit;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wall_query_arb_if #(.NREQ(NREQ), .CW(CW)) bus ();

    wall_query_arb #(
        .NREQ    (NREQ),
        .CW      (CW),
        .MAP_LAT (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    // Map: border and a block at x 30..69, y 20..69 are wall; off-map is wall.
    function automatic logic is_wall(logic [CW-1:0] x, logic [CW-1:0] y);
        if (x >= 8'd200 || y >= 8'd144) return 1'b1;
        if (x == 8'd0 || y == 8'd0 || x == 8'd199 || y == 8'd143) return 1'b1;
        if (x >= 8'd30 && x < 8'd70 && y >= 8'd20 && y < 8'd70) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) bus.map_hit <= is_wall(bus.map_x, bus.map_y);

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endfunction

    // Monitor: every ack pulse is one transaction matched against the queue.
    always @(negedge clk) begin
        if (!rst && bus.ack != '0) begin
            exp_t e;
            check("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got ack=%b, expected none", bus.ack);
            end else begin
                e = exp_q.pop_front();
                $display("txn t=%0t ack=%b hit=%b (exp ack=%b hit=%b)",
                         $time, bus.ack, bus.hit, e.ack, e.hit);
                check("ack", 32'(bus.ack), 32'(e.ack));
                check("hit", 32'(bus.hit), 32'(e.hit));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_xy(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y);
        bus.req_x[i*CW +: CW] = x;
        bus.req_y[i*CW +: CW] = y;
    endtask

    task automatic expect_txn(input logic [NREQ-1:0] a, input logic h);
        exp_t e;
        e.ack = a;
        e.hit = h;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        tick(2);
        check("rst_ack",   32'(bus.ack),   32'd0);
        check("rst_hit",   32'(bus.hit),   32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_map_x", 32'(bus.map_x), 32'd0);
        check("rst_map_y", 32'(bus.map_y), 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50; i++) begin
            if (!bus.busy && bus.ack == '0) break;
            tick(1);
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.req   = '0;
        bus.req_x = '0;
        bus.req_y = '0;

        // 1: single requester at the wall corner
        do_reset();
        set_xy(0, 8'd0, 8'd0);
        bus.req = 4'b0001;
        expect_txn(4'b0001, 1'b1);
        tick(1);
        check("t1_map_x", 32'(bus.map_x), 32'd0);
        check("t1_map_y", 32'(bus.map_y), 32'd0);
        check("t1_busy_e0", 32'(bus.busy), 32'd1);
        tick(1);
        check("t1_ack_e1", 32'(bus.ack), 32'd0);
        tick(1);
        check("t1_ack_e2", 32'(bus.ack), 32'b0001);
        check("t1_busy_e2", 32'(bus.busy), 32'd1);
        tick(1);
        check("t1_ack_e3", 32'(bus.ack), 32'd0);
        check("t1_busy_e3", 32'(bus.busy), 32'd0);
        bus.req = '0;

        // 2: open floor
        set_xy(1, 8'd100, 8'd50);
        bus.req = 4'b0010;
        expect_txn(4'b0010, 1'b0);
        tick(1);
        check("t2_map_x", 32'(bus.map_x), 32'd100);
        check("t2_map_y", 32'(bus.map_y), 32'd50);
        tick(3);
        bus.req = '0;
        wait_idle("t2_idle");

        // 3: all pending, strict rotation from ptr=0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_xy(i, 8'd60, 8'd60);
        bus.req = 4'b1111;
        expect_txn(4'b0001, 1'b1);
        expect_txn(4'b0010, 1'b1);
        expect_txn(4'b0100, 1'b1);
        expect_txn(4'b1000, 1'b1);
        expect_txn(4'b0001, 1'b1);
        tick(20);
        bus.req = '0;
        wait_idle("t3_idle");

        // 4: back-to-back with coords updated at the ack edge
        do_reset();
        set_xy(2, 8'd40, 8'd30);
        bus.req = 4'b0100;
        expect_txn(4'b0100, 1'b1);
        expect_txn(4'b0100, 1'b0);
        tick(3);
        check("t4_ack_first", 32'(bus.ack), 32'b0100);
        tick(1);
        set_xy(2, 8'd100, 8'd50);
        tick(3);
        check("t4_ack_second", 32'(bus.ack), 32'b0100);
        tick(1);
        bus.req = '0;
        wait_idle("t4_idle");

        // 5: reset during WAIT abandons the query
        do_reset();
        set_xy(0, 8'd100, 8'd50);
        bus.req = 4'b0001;
        tick(1);
        check("t5_map_x_grant", 32'(bus.map_x), 32'd100);
        rst = 1'b1;
        tick(1);
        check("t5_ack_rst", 32'(bus.ack), 32'd0);
        check("t5_busy_rst", 32'(bus.busy), 32'd0);
        check("t5_map_x_rst", 32'(bus.map_x), 32'd0);
        rst = 1'b0;
        set_xy(0, 8'd60, 8'd60);
        set_xy(1, 8'd100, 8'd50);
        bus.req = 4'b0011;
        expect_txn(4'b0001, 1'b1);
        expect_txn(4'b0010, 1'b0);
        tick(4);
        bus.req = 4'b0010;
        tick(4);
        bus.req = '0;
        wait_idle("t5_idle");

        // 6: off-map coords, req dropped right after grant
        do_reset();
        set_xy(3, 8'd250, 8'd10);
        bus.req = 4'b1000;
        expect_txn(4'b1000, 1'b1);
        tick(1);
        check("t6_map_x", 32'(bus.map_x), 32'd250);
        bus.req = '0;
        tick(1);
        wait_idle("t6_idle");

        tick(4);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
